// File: rtl/reimu_life.sv
// reimu_life: player hit/life manager sequencing death, respawn invulnerability and game over.
// Ports: clk22/rst (sync active-high)/gamestart (holds IDLE); boss_shot/enemy_shot hit flags;
// lives, reimu_alive, invuln, reimu_visible, hit_pulse, respawn, gameover, all registered.
// Build option: define REIMU_BLINK_EN to blink the sprite from tmr[BLINK_BIT] while invulnerable.
module reimu_life #(
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_TICKS  = 16,
  parameter int INVULN_TICKS = 48,
  parameter int BLINK_BIT    = 2
) (
  input  logic       clk22,
  input  logic       rst,
  input  logic       gamestart,
  input  logic       boss_shot,
  input  logic       enemy_shot,
  output logic [2:0] lives,
  output logic       reimu_alive,
  output logic       invuln,
  output logic       reimu_visible,
  output logic       hit_pulse,
  output logic       respawn,
  output logic       gameover
);
  typedef enum logic [2:0] {IDLE, ALIVE, DYING, INVULN, GAMEOVER} state_t;
`ifdef REIMU_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [2:0] lives_d;
  logic hit_pulse_d, respawn_d, alive_d, invuln_d, visible_d, gameover_d;
  logic hit;
  assign hit = boss_shot | enemy_shot;
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    lives_d     = lives;
    hit_pulse_d = 1'b0;
    respawn_d   = 1'b0;
    case (state_q)
      IDLE: state_d = ALIVE;
      ALIVE: if (hit) begin
        state_d     = DYING;
        lives_d     = lives == 3'd0 ? 3'd0 : lives - 3'd1;
        tmr_d       = 8'(DEATH_TICKS - 1);
        hit_pulse_d = 1'b1;
      end
      DYING: if (tmr_q != 8'd0) tmr_d = tmr_q - 8'd1;
        else if (lives == 3'd0) state_d = GAMEOVER;
        else begin
          state_d   = INVULN;
          tmr_d     = 8'(INVULN_TICKS - 1);
          respawn_d = 1'b1;
        end
      INVULN: if (tmr_q != 8'd0) tmr_d = tmr_q - 8'd1;
        else state_d = ALIVE;
      default: ;
    endcase
    if (gamestart) begin
      state_d     = IDLE;
      lives_d     = 3'(LIVES_INIT);
      tmr_d       = 8'd0;
      hit_pulse_d = 1'b0;
      respawn_d   = 1'b0;
    end
    // Outputs decode from the next state so they change on the edge that samples the cause.
    alive_d    = state_d == ALIVE || state_d == INVULN;
    invuln_d   = state_d == INVULN;
    gameover_d = state_d == GAMEOVER;
    visible_d  = state_d == ALIVE || (state_d == INVULN && (tmr_d[BLINK_BIT] || !BLINK_EN));
  end
  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q       <= IDLE;
      tmr_q         <= 8'd0;
      lives         <= 3'(LIVES_INIT);
      reimu_alive   <= 1'b0;
      invuln        <= 1'b0;
      reimu_visible <= 1'b0;
      hit_pulse     <= 1'b0;
      respawn       <= 1'b0;
      gameover      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      lives         <= lives_d;
      reimu_alive   <= alive_d;
      invuln        <= invuln_d;
      reimu_visible <= visible_d;
      hit_pulse     <= hit_pulse_d;
      respawn       <= respawn_d;
      gameover      <= gameover_d;
    end
  end
endmodule

// File: tb/tb_reimu_life.sv
// tb_reimu_life: directed self-checking bench for reimu_life with default parameters.
module tb_reimu_life;
  logic clk22 = 1'b0, rst = 1'b1, gamestart = 1'b0, boss_shot = 1'b0, enemy_shot = 1'b0;
  logic [2:0] lives;
  logic reimu_alive, invuln, reimu_visible, hit_pulse, respawn, gameover;
  int tests = 0, fails = 0;
  reimu_life dut (
    .clk22(clk22), .rst(rst), .gamestart(gamestart), .boss_shot(boss_shot),
    .enemy_shot(enemy_shot), .lives(lives), .reimu_alive(reimu_alive), .invuln(invuln),
    .reimu_visible(reimu_visible), .hit_pulse(hit_pulse), .respawn(respawn), .gameover(gameover)
  );
  always #5 clk22 = ~clk22;
  task automatic tick();
    @(posedge clk22);
    #1;
  endtask
  function automatic logic exp_vis(input int t);
`ifdef REIMU_BLINK_EN
    return 1'((t >> 2) & 1);
`else
    return 1'b1;
`endif
  endfunction
  task automatic start();
    rst = 1'b1; gamestart = 1'b0; boss_shot = 1'b0; enemy_shot = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1; gamestart = 1'b0;
    tick(); tick();
    tests++;
    if ({lives, reimu_alive, invuln, reimu_visible, hit_pulse, respawn, gameover} !== {3'd3, 6'b0}) begin
      fails++;
      $display("FAIL reset: lives=%0d alive=%b inv=%b vis=%b hp=%b rs=%b go=%b, need lives=3 rest 0",
               lives, reimu_alive, invuln, reimu_visible, hit_pulse, respawn, gameover);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({lives, reimu_alive, reimu_visible, invuln} !== {3'd3, 3'b110}) begin
      fails++;
      $display("FAIL start: lives=%0d alive=%b vis=%b inv=%b, need 3 1 1 0", lives, reimu_alive, reimu_visible, invuln);
    end
  endtask
  task automatic test_single_hit();
    int bad;
    start();
    boss_shot = 1'b1;
    tick();
    boss_shot = 1'b0;
    tests++;
    if ({hit_pulse, lives, reimu_alive, reimu_visible} !== {1'b1, 3'd2, 2'b00}) begin
      fails++;
      $display("FAIL hit: hp=%b lives=%0d alive=%b vis=%b, need 1 2 0 0", hit_pulse, lives, reimu_alive, reimu_visible);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (reimu_alive !== 1'b0 || respawn !== 1'b0 || hit_pulse !== 1'b0 || invuln !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL dying_dwell: %0d bad cycles, need 0", bad);
    end
    tick();
    tests++;
    if ({respawn, invuln, reimu_alive, reimu_visible} !== {3'b111, exp_vis(47)}) begin
      fails++;
      $display("FAIL respawn: rs=%b inv=%b alive=%b vis=%b, need 1 1 1 %b", respawn, invuln, reimu_alive, reimu_visible, exp_vis(47));
    end
    bad = 0;
    for (int i = 1; i < 48; i++) begin
      tick();
      if (respawn !== 1'b0 || invuln !== 1'b1 || reimu_alive !== 1'b1 || reimu_visible !== exp_vis(47 - i)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL invuln_dwell: %0d bad cycles, need 0", bad);
    end
    tick();
    tests++;
    if ({invuln, reimu_alive, reimu_visible, lives} !== {3'b011, 3'd2}) begin
      fails++;
      $display("FAIL back_alive: inv=%b alive=%b vis=%b lives=%0d, need 0 1 1 2", invuln, reimu_alive, reimu_visible, lives);
    end
  endtask
  task automatic test_held_hit();
    int pulses, rsp, clash, go_at;
    int pe[3];
    start();
    enemy_shot = 1'b1;
    pulses = 0; rsp = 0; clash = 0; go_at = 0;
    for (int c = 1; c <= 160; c++) begin
      tick();
      if (hit_pulse && respawn) clash++;
      if (respawn === 1'b1) rsp++;
      if (hit_pulse === 1'b1) begin
        if (pulses < 3) pe[pulses] = c;
        pulses++;
      end
      if (gameover === 1'b1 && go_at == 0) go_at = c;
    end
    enemy_shot = 1'b0;
    tests++;
    if (pulses != 3 || pe[0] != 1 || pe[1] != 66 || pe[2] != 131) begin
      fails++;
      $display("FAIL held_pulses: n=%0d at %0d,%0d,%0d, need 3 at 1,66,131", pulses, pe[0], pe[1], pe[2]);
    end
    tests++;
    if (rsp != 2 || clash != 0) begin
      fails++;
      $display("FAIL held_respawn: respawns=%0d clashes=%0d, need 2 0", rsp, clash);
    end
    tests++;
    if (go_at != 147 || gameover !== 1'b1 || lives !== 3'd0 || reimu_alive !== 1'b0 || reimu_visible !== 1'b0) begin
      fails++;
      $display("FAIL gameover: at=%0d go=%b lives=%0d alive=%b vis=%b, need 147 1 0 0 0", go_at, gameover, lives, reimu_alive, reimu_visible);
    end
    boss_shot = 1'b1;
    tick(); tick();
    boss_shot = 1'b0;
    tests++;
    if (gameover !== 1'b1 || hit_pulse !== 1'b0 || lives !== 3'd0) begin
      fails++;
      $display("FAIL gameover_hold: go=%b hp=%b lives=%0d, need 1 0 0", gameover, hit_pulse, lives);
    end
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    tests++;
    if (gameover !== 1'b0 || lives !== 3'd3 || reimu_alive !== 1'b0) begin
      fails++;
      $display("FAIL gameover_restart: go=%b lives=%0d alive=%b, need 0 3 0", gameover, lives, reimu_alive);
    end
  endtask
  task automatic test_simultaneous();
    start();
    boss_shot = 1'b1; enemy_shot = 1'b1;
    tick();
    boss_shot = 1'b0; enemy_shot = 1'b0;
    tests++;
    if (hit_pulse !== 1'b1 || lives !== 3'd2) begin
      fails++;
      $display("FAIL simul_hit: hp=%b lives=%0d, need 1 2", hit_pulse, lives);
    end
    tick();
    tests++;
    if (hit_pulse !== 1'b0 || lives !== 3'd2) begin
      fails++;
      $display("FAIL simul_after: hp=%b lives=%0d, need 0 2", hit_pulse, lives);
    end
  endtask
  task automatic test_abort();
    start();
    boss_shot = 1'b1;
    tick();
    boss_shot = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    tests++;
    if (respawn !== 1'b1) begin
      fails++;
      $display("FAIL abort_setup: rs=%b, need 1", respawn);
    end
    for (int i = 0; i < 4; i++) tick();
    gamestart = 1'b1;
    tick();
    tests++;
    if ({lives, invuln, respawn, reimu_alive, reimu_visible} !== {3'd3, 4'b0000}) begin
      fails++;
      $display("FAIL abort_invuln: lives=%0d inv=%b rs=%b alive=%b vis=%b, need 3 0 0 0 0", lives, invuln, respawn, reimu_alive, reimu_visible);
    end
    tick();
    gamestart = 1'b0;
    tick();
    tests++;
    if (reimu_alive !== 1'b1 || lives !== 3'd3) begin
      fails++;
      $display("FAIL abort_resume: alive=%b lives=%0d, need 1 3", reimu_alive, lives);
    end
    enemy_shot = 1'b1;
    tick();
    enemy_shot = 1'b0;
    tick(); tick();
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    tests++;
    if (lives !== 3'd3 || respawn !== 1'b0 || reimu_alive !== 1'b0) begin
      fails++;
      $display("FAIL abort_dying: lives=%0d rs=%b alive=%b, need 3 0 0", lives, respawn, reimu_alive);
    end
  endtask
  initial begin
    test_reset();
    test_single_hit();
    test_held_hit();
    test_simultaneous();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
